// File: rtl/sys_axi_pkg.sv
// Shared types and AXI3 constants for the system-bus to AXI3 master bridge.
package sys_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_ACK
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding is log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned sw);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ((32'd1 << i) <= sw) s = 3'(i);
    end
    return s;
  endfunction

  function automatic logic resp_err(input logic [1:0] resp);
    logic e;
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   e = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: e = 1'b1;
      default:                          e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sys_axi_master.sv
// System-bus to AXI3 master: one single-beat transaction outstanding at a time.
// state | meaning: IDLE wait cmd; WR_REQ aw/w valid; WR_RESP bready; RD_REQ arvalid; RD_DATA rready; ACK pulse
module sys_axi_master
  import sys_axi_pkg::*;
#(
  parameter int unsigned       AXI_DW = 32,
  parameter int unsigned       AXI_AW = 32,
  parameter int unsigned       AXI_IW = 8,
  parameter int unsigned       AXI_SW = AXI_DW >> 3,
  parameter logic [AXI_IW-1:0] AXI_ID = '0
) (
  input  logic              axi_clk_i,
  input  logic              axi_rstn_i,
  input  logic [AXI_AW-1:0] sys_addr_i,
  input  logic [AXI_DW-1:0] sys_wdata_i,
  input  logic [AXI_SW-1:0] sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [AXI_DW-1:0] sys_rdata_o,
  output logic              sys_err_o,
  output logic              sys_ack_o,
  output logic              sys_busy_o,
  output logic [AXI_IW-1:0] axi_awid_o,
  output logic [AXI_AW-1:0] axi_awaddr_o,
  output logic [3:0]        axi_awlen_o,
  output logic [2:0]        axi_awsize_o,
  output logic [1:0]        axi_awburst_o,
  output logic [1:0]        axi_awlock_o,
  output logic [3:0]        axi_awcache_o,
  output logic [2:0]        axi_awprot_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  output logic [AXI_IW-1:0] axi_wid_o,
  output logic [AXI_DW-1:0] axi_wdata_o,
  output logic [AXI_SW-1:0] axi_wstrb_o,
  output logic              axi_wlast_o,
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  input  logic [AXI_IW-1:0] axi_bid_i,
  input  logic [1:0]        axi_bresp_i,
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  output logic [AXI_IW-1:0] axi_arid_o,
  output logic [AXI_AW-1:0] axi_araddr_o,
  output logic [3:0]        axi_arlen_o,
  output logic [2:0]        axi_arsize_o,
  output logic [1:0]        axi_arburst_o,
  output logic [1:0]        axi_arlock_o,
  output logic [3:0]        axi_arcache_o,
  output logic [2:0]        axi_arprot_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  input  logic [AXI_IW-1:0] axi_rid_i,
  input  logic [AXI_DW-1:0] axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o
);

  localparam logic [2:0] AXI_SIZE = axi_size(AXI_SW);

  state_t            state_q, state_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              pend_rd_q, pend_rd_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [AXI_DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AXI_SW-1:0] sel_q, sel_d;
  logic              err_q, err_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, ack_q, ack_d, busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    pend_rd_d = pend_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (sys_wen_i || sys_ren_i) begin
          addr_d  = sys_addr_i;
          wdata_d = sys_wdata_i;
          sel_d   = sys_sel_i;
        end
        if (sys_wen_i) begin
          state_d   = ST_WR_REQ;
          pend_rd_d = sys_ren_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (sys_ren_i) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid_q & axi_awready_i);
        w_done_d  = w_done_q  | (wvalid_q  & axi_wready_i);
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (axi_bvalid_i && bready_q) begin
          err_d   = resp_err(axi_bresp_i) | (axi_bid_i != AXI_ID);
          state_d = ST_ACK;
        end
      end
      ST_RD_REQ: begin
        if (arvalid_q && axi_arready_i) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (axi_rvalid_i && rready_q) begin
          rdata_d = axi_rdata_i;
          err_d   = resp_err(axi_rresp_i) | (axi_rid_i != AXI_ID) | ~axi_rlast_i;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // A read queued behind a simultaneous write reuses the latched address.
        if (pend_rd_q) begin
          state_d   = ST_RD_REQ;
          pend_rd_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    awvalid_d = (state_d == ST_WR_REQ) && !aw_done_d;
    wvalid_d  = (state_d == ST_WR_REQ) && !w_done_d;
    bready_d  = (state_d == ST_WR_RESP);
    arvalid_d = (state_d == ST_RD_REQ);
    rready_d  = (state_d == ST_RD_DATA);
    ack_d     = (state_d == ST_ACK);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      pend_rd_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      pend_rd_q <= pend_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign sys_rdata_o   = rdata_q;
  assign sys_err_o     = err_q;
  assign sys_ack_o     = ack_q;
  assign sys_busy_o    = busy_q;

  assign axi_awid_o    = AXI_ID;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = 4'd0;
  assign axi_awsize_o  = AXI_SIZE;
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'd0;
  assign axi_awprot_o  = 3'd0;
  assign axi_awvalid_o = awvalid_q;

  assign axi_wid_o     = AXI_ID;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = sel_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_wvalid_o  = wvalid_q;

  assign axi_bready_o  = bready_q;

  assign axi_arid_o    = AXI_ID;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = 4'd0;
  assign axi_arsize_o  = AXI_SIZE;
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = 4'd0;
  assign axi_arprot_o  = 3'd0;
  assign axi_arvalid_o = arvalid_q;

  assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_sys_axi_master.sv
// Bench for sys_axi_master: AXI slave model with programmable wait states and responses.
module tb_sys_axi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
  logic [3:0]  sys_sel = '0;
  logic        sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack, sys_busy;

  logic [7:0]  awid, wid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  awlen, awcache, arlen, arcache, wstrb;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, awlock, arburst, arlock;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 1;
  logic [7:0]  bid = 0, rid = 0;
  logic [1:0]  bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;

  int checks = 0, failures = 0, cyc = 0, ack_total = 0;

  int cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [7:0]  cfg_bid, cfg_rid;
  logic        cfg_rlast;
  logic [31:0] cfg_rdata;

  int aw_beats = 0, w_beats = 0, ar_beats = 0, cap_aw_cyc = 0, cap_ar_cyc = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb, cap_awlen, cap_arlen;
  logic [2:0]  cap_awsize, cap_arsize;
  logic [1:0]  cap_awburst;
  logic        cap_wlast;
  logic [7:0]  cap_awid, cap_wid, cap_arid;

  logic [31:0] model_rdata = '0;

  sys_axi_master dut (
    .axi_clk_i(clk), .axi_rstn_i(rst_n),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack), .sys_busy_o(sys_busy),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awlock_o(awlock), .axi_awcache_o(awcache), .axi_awprot_o(awprot),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wid_o(wid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache), .axi_arprot_o(arprot),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (sys_ack === 1'b1) ack_total++;

  // Slave model: decisions made on the falling edge, handshakes land on the next rising edge.
  bit aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_seen, w_seen, b_pend, r_pend;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
    end else begin
      if (aw_fire) begin awready = 0; aw_fire = 0; aw_seen = 1; end
      else if (awvalid && !awready) begin
        if (aw_cnt >= cfg_aw_d) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
      end
      if (awready && awvalid) begin
        aw_fire = 1; aw_beats++; cap_aw_cyc = cyc;
        cap_awaddr = awaddr; cap_awlen = awlen; cap_awsize = awsize; cap_awburst = awburst; cap_awid = awid;
      end
      if (w_fire) begin wready = 0; w_fire = 0; w_seen = 1; end
      else if (wvalid && !wready) begin
        if (w_cnt >= cfg_w_d) begin wready = 1; w_cnt = 0; end else w_cnt++;
      end
      if (wready && wvalid) begin
        w_fire = 1; w_beats++;
        cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; cap_wid = wid;
      end
      if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0; end
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      else if (b_pend && !bvalid) begin
        if (b_cnt >= cfg_b_d) begin bvalid = 1; b_pend = 0; bresp = cfg_bresp; bid = cfg_bid; end
        else b_cnt++;
      end
      if (bvalid && bready) b_fire = 1;
      if (ar_fire) begin arready = 0; ar_fire = 0; r_pend = 1; r_cnt = 0; end
      else if (arvalid && !arready) begin
        if (ar_cnt >= cfg_ar_d) begin arready = 1; ar_cnt = 0; end else ar_cnt++;
      end
      if (arready && arvalid) begin
        ar_fire = 1; ar_beats++; cap_ar_cyc = cyc;
        cap_araddr = araddr; cap_arlen = arlen; cap_arsize = arsize; cap_arid = arid;
      end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      else if (r_pend && !rvalid) begin
        if (r_cnt >= cfg_r_d) begin
          rvalid = 1; r_pend = 0; rdata = cfg_rdata; rresp = cfg_rresp; rid = cfg_rid; rlast = cfg_rlast;
        end else r_cnt++;
      end
      if (rvalid && rready) r_fire = 1;
    end
  end

  task automatic set_slave(input int aw_d, w_d, b_d, ar_d, r_d);
    cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d; cfg_ar_d = ar_d; cfg_r_d = r_d;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_bid = 8'd0; cfg_rid = 8'd0; cfg_rlast = 1'b1;
    cfg_rdata = $urandom;
  endtask

  task automatic send(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int t0);
    @(negedge clk);
    sys_addr = a; sys_wdata = d; sys_sel = s; sys_wen = w; sys_ren = r; t0 = cyc;
    @(negedge clk);
    sys_wen = 0; sys_ren = 0;
    sys_addr = $urandom; sys_wdata = $urandom; sys_sel = 4'($urandom);
  endtask

  task automatic wait_ack(output bit timeout, output int at, output logic err, output logic [31:0] rd);
    timeout = 1; at = 0; err = 0; rd = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sys_ack === 1'b1) begin timeout = 0; at = cyc; err = sys_err; rd = sys_rdata; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, sys_ack, sys_err, sys_busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000000", {awvalid, wvalid, bready, arvalid, rready, sys_ack, sys_err, sys_busy});
    end
    checks++;
    if (sys_rdata !== 32'h0 || awaddr !== 32'h0) begin
      failures++; $display("FAIL reset_data rdata=%h addr=%h want=0", sys_rdata, awaddr);
    end
  endtask

  task automatic test_write_zero_wait;
    int t0, at, aw0, w0; bit to; logic err; logic [31:0] rd;
    set_slave(0, 0, 0, 0, 0);
    aw0 = aw_beats; w0 = w_beats;
    send(1, 0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, t0);
    wait_ack(to, at, err, rd);
    checks++; if (to) begin failures++; $display("FAIL wr0_timeout got=timeout want=ack"); end
    checks++; if (at - t0 != 3) begin failures++; $display("FAIL wr0_latency got=%0d want=3", at - t0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr0_err got=%b want=0", err); end
    checks++; if (rd !== model_rdata) begin failures++; $display("FAIL wr0_rdata_hold got=%h want=%h", rd, model_rdata); end
    checks++;
    if (aw_beats - aw0 != 1 || w_beats - w0 != 1) begin
      failures++; $display("FAIL wr0_beats got aw=%0d w=%0d want 1/1", aw_beats - aw0, w_beats - w0);
    end
    checks++;
    if (cap_awaddr !== 32'h4000_0010 || cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'hF) begin
      failures++; $display("FAIL wr0_beat got a=%h d=%h s=%h want 40000010/deadbeef/f", cap_awaddr, cap_wdata, cap_wstrb);
    end
    checks++;
    if (cap_awlen !== 4'd0 || cap_awsize !== 3'd2 || cap_awburst !== 2'b01 || cap_wlast !== 1'b1 ||
        cap_awid !== 8'd0 || cap_wid !== 8'd0) begin
      failures++; $display("FAIL wr0_fields got len=%0d size=%0d burst=%0d wlast=%b want 0/2/1/1",
                           cap_awlen, cap_awsize, cap_awburst, cap_wlast);
    end
    @(negedge clk);
    checks++;
    if (sys_ack !== 1'b0 || sys_busy !== 1'b0) begin
      failures++; $display("FAIL wr0_after_ack got ack=%b busy=%b want 0/0", sys_ack, sys_busy);
    end
  endtask

  task automatic test_read_waits;
    int t0, at, ar0; bit to; logic err; logic [31:0] rd;
    set_slave(0, 0, 0, 5, 3);
    cfg_rdata = 32'h1234_5678;
    ar0 = ar_beats;
    send(0, 1, 32'h4000_0020, 32'h0, 4'hF, t0);
    wait_ack(to, at, err, rd);
    model_rdata = 32'h1234_5678;
    checks++; if (to) begin failures++; $display("FAIL rd_timeout got=timeout want=ack"); end
    checks++; if (at - t0 != 3 + 5 + 3) begin failures++; $display("FAIL rd_latency got=%0d want=11", at - t0); end
    checks++; if (rd !== 32'h1234_5678 || err !== 1'b0) begin
      failures++; $display("FAIL rd_data got=%h err=%b want=12345678 err=0", rd, err);
    end
    checks++;
    if (ar_beats - ar0 != 1 || cap_araddr !== 32'h4000_0020 || cap_arlen !== 4'd0 || cap_arsize !== 3'd2 || cap_arid !== 8'd0) begin
      failures++; $display("FAIL rd_ar got n=%0d a=%h len=%0d size=%0d want 1/40000020/0/2",
                           ar_beats - ar0, cap_araddr, cap_arlen, cap_arsize);
    end
  endtask

  task automatic test_split_handshake;
    int t0, at, aw0, w0; bit to; logic err; logic [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_slave(4, 0, 0, 0, 0); else set_slave(0, 4, 0, 0, 0);
      aw0 = aw_beats; w0 = w_beats;
      send(1, 0, 32'h4000_0100 + k, 32'hA5A5_0000 + k, 4'h3, t0);
      @(negedge clk);
      checks++;
      if (awvalid !== (k == 0) || wvalid !== (k == 1)) begin
        failures++; $display("FAIL split%0d_valids got aw=%b w=%b want aw=%0d w=%0d", k, awvalid, wvalid, k == 0, k == 1);
      end
      wait_ack(to, at, err, rd);
      checks++;
      if (to || at - t0 != 7 || err !== 1'b0) begin
        failures++; $display("FAIL split%0d_ack got to=%b lat=%0d err=%b want 0/7/0", k, to, at - t0, err);
      end
      checks++;
      if (aw_beats - aw0 != 1 || w_beats - w0 != 1 || cap_wdata !== 32'hA5A5_0000 + k || cap_wstrb !== 4'h3) begin
        failures++; $display("FAIL split%0d_beats got aw=%0d w=%0d d=%h s=%h want 1/1/%h/3",
                             k, aw_beats - aw0, w_beats - w0, cap_wdata, cap_wstrb, 32'hA5A5_0000 + k);
      end
      @(negedge clk);
      checks++; if (sys_ack !== 1'b0) begin failures++; $display("FAIL split%0d_ack_width got=%b want=0", k, sys_ack); end
    end
  endtask

  task automatic test_back_to_back;
    int t0, a1, a2, aw0, ar0; bit to1, to2; logic e1, e2; logic [31:0] r1, r2, exp_rd;
    set_slave(0, 0, 0, 0, 0);
    exp_rd = cfg_rdata;
    aw0 = aw_beats; ar0 = ar_beats;
    send(1, 1, 32'h4000_0200, 32'h0BAD_F00D, 4'hC, t0);
    wait_ack(to1, a1, e1, r1);
    wait_ack(to2, a2, e2, r2);
    checks++;
    if (to1 || to2 || a1 - t0 != 3 || a2 - t0 != 6) begin
      failures++; $display("FAIL b2b_acks got to=%b%b at=%0d,%0d want 3,6", to1, to2, a1 - t0, a2 - t0);
    end
    checks++;
    if (r1 !== model_rdata || r2 !== exp_rd || e1 !== 1'b0 || e2 !== 1'b0) begin
      failures++; $display("FAIL b2b_data got r1=%h r2=%h e=%b%b want %h %h 00", r1, r2, e1, e2, model_rdata, exp_rd);
    end
    model_rdata = exp_rd;
    checks++;
    if (aw_beats - aw0 != 1 || ar_beats - ar0 != 1 || cap_araddr !== 32'h4000_0200 || cap_aw_cyc >= cap_ar_cyc) begin
      failures++; $display("FAIL b2b_order got aw=%0d ar=%0d araddr=%h awc=%0d arc=%0d want write before read at 40000200",
                           aw_beats - aw0, ar_beats - ar0, cap_araddr, cap_aw_cyc, cap_ar_cyc);
    end
  endtask

  task automatic test_errors;
    int t0, at; bit to; logic err; logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      set_slave(1, 0, 1, 0, 2);
      if (k == 0) cfg_bresp = 2'b10;
      if (k == 1) cfg_rid = 8'h05;
      if (k == 2) cfg_rlast = 1'b0;
      send(k == 0, k != 0, 32'h4000_0300 + 4 * k, 32'h1111_1111 * k, 4'hF, t0);
      wait_ack(to, at, err, rd);
      if (k != 0) model_rdata = cfg_rdata;
      checks++;
      if (to || err !== 1'b1 || rd !== model_rdata) begin
        failures++; $display("FAIL err_case%0d got to=%b err=%b rd=%h want err=1 rd=%h", k, to, err, rd, model_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_txn;
    int t0, at, acks0; bit to; logic err; logic [31:0] rd;
    set_slave(50, 50, 0, 0, 0);
    send(1, 0, 32'h4000_0400, 32'h7777_7777, 4'hF, t0);
    @(negedge clk);
    acks0 = ack_total;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, sys_ack, sys_busy} !== 7'h00 || sys_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_mid got=%b rdata=%h want all 0",
                           {awvalid, wvalid, bready, arvalid, rready, sys_ack, sys_busy}, sys_rdata);
    end
    model_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ack_total != acks0) begin failures++; $display("FAIL rst_no_ack got=%0d want=0", ack_total - acks0); end
    set_slave(0, 0, 0, 0, 0);
    send(0, 1, 32'h4000_0404, 32'h0, 4'hF, t0);
    wait_ack(to, at, err, rd);
    model_rdata = cfg_rdata;
    checks++;
    if (to || at - t0 != 3 || err !== 1'b0 || rd !== model_rdata || cap_araddr !== 32'h4000_0404) begin
      failures++; $display("FAIL rst_recover got to=%b lat=%0d err=%b rd=%h want 0/3/0/%h", to, at - t0, err, rd, model_rdata);
    end
  endtask

  task automatic test_random;
    int t0, a1, a2, op, aw0, w0, ar0, exp_wlat, exp_rlat;
    bit to1, to2; logic e1, e2, exp_we, exp_re; logic [31:0] r1, r2, addr, data; logic [3:0] sel;
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 2);
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom);
      if ($urandom_range(0, 3) == 0) cfg_bid = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) cfg_rid = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) cfg_rlast = 1'b0;
      addr = $urandom; data = $urandom; sel = 4'($urandom);
      exp_wlat = 3 + ((cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d) + cfg_b_d;
      exp_rlat = 3 + cfg_ar_d + cfg_r_d;
      exp_we = (cfg_bresp >= 2) || (cfg_bid != 0);
      exp_re = (cfg_rresp >= 2) || (cfg_rid != 0) || !cfg_rlast;
      aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
      send(op != 1, op != 0, addr, data, sel, t0);
      wait_ack(to1, a1, e1, r1);
      checks++;
      if (to1 || a1 - t0 != ((op == 1) ? exp_rlat : exp_wlat)) begin
        failures++; $display("FAIL rnd%0d_lat1 op=%0d got to=%b lat=%0d want %0d", n, op, to1, a1 - t0, (op == 1) ? exp_rlat : exp_wlat);
      end
      if (op == 1) model_rdata = cfg_rdata;
      checks++;
      if (e1 !== ((op == 1) ? exp_re : exp_we) || r1 !== model_rdata) begin
        failures++; $display("FAIL rnd%0d_resp1 op=%0d got err=%b rd=%h want err=%b rd=%h",
                             n, op, e1, r1, (op == 1) ? exp_re : exp_we, model_rdata);
      end
      if (op == 2) begin
        wait_ack(to2, a2, e2, r2);
        model_rdata = cfg_rdata;
        checks++;
        if (to2 || a2 - a1 != exp_rlat || e2 !== exp_re || r2 !== model_rdata) begin
          failures++; $display("FAIL rnd%0d_resp2 got to=%b gap=%0d err=%b rd=%h want gap=%0d err=%b rd=%h",
                               n, to2, a2 - a1, e2, r2, exp_rlat, exp_re, model_rdata);
        end
      end
      checks++;
      if (aw_beats - aw0 != ((op != 1) ? 1 : 0) || w_beats - w0 != ((op != 1) ? 1 : 0) ||
          ar_beats - ar0 != ((op != 0) ? 1 : 0) ||
          (op != 1 && (cap_awaddr !== addr || cap_wdata !== data || cap_wstrb !== sel)) ||
          (op != 0 && cap_araddr !== addr)) begin
        failures++; $display("FAIL rnd%0d_beats op=%0d got aw=%0d w=%0d ar=%0d awa=%h wd=%h ws=%h ara=%h want addr=%h data=%h sel=%h",
                             n, op, aw_beats - aw0, w_beats - w0, ar_beats - ar0, cap_awaddr, cap_wdata, cap_wstrb,
                             cap_araddr, addr, data, sel);
      end
      @(negedge clk);
      checks++;
      if (sys_ack !== 1'b0 || sys_busy !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_idle got ack=%b busy=%b want 0/0", n, sys_ack, sys_busy);
      end
    end
  endtask

  initial begin
    set_slave(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_write_zero_wait;
    test_read_waits;
    test_split_handshake;
    test_back_to_back;
    test_errors;
    test_reset_mid_txn;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
